// File: rtl/psubsb_pipe.sv
// psubsb_pipe: packed signed-byte saturating subtract (out = in1 - in2 per lane, clamped to [-128,127]).
// Latency: 2 cycles from input handshake to out_valid; throughput 1 result/cycle.
// Backpressure: out/sat/out_valid hold while out_ready=0; in_ready drops once both stages are full.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready     operand handshake; in1 = minuend, in2 = subtrahend, lane k = bits [8k+7:8k]
//   out_valid/out_ready   result handshake; out = packed saturated difference, sat = per-lane clamp flags
//   sat_sticky/clr_sticky sticky "some accepted result saturated"; a set beats a clear in the same cycle
// Optional: define PSUB_FLAGS_EN to add registered result flags zr (out==0), neg (out MSB), ov (|sat).
module psubsb_pipe #(
  parameter int LANES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [LANES*8-1:0] in1,
  input  logic [LANES*8-1:0] in2,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LANES*8-1:0] out,
  output logic [LANES-1:0]   sat,
  output logic               sat_sticky,
  input  logic               clr_sticky
`ifdef PSUB_FLAGS_EN
  ,
  output logic               zr,
  output logic               neg,
  output logic               ov
`endif
);

  localparam int W = LANES * 8;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
  } opnd_t;

  opnd_t          s1_op;
  logic           s1_valid;
  logic           s2_adv;
  logic [W-1:0]   diff_dat;
  logic [LANES-1:0] diff_sat;
  logic [7:0]     a_l;
  logic [7:0]     b_l;
  logic [7:0]     d_l;

  // Stage 2 (the output register) drains when empty or when the consumer takes it.
  assign s2_adv   = s1_valid & (~out_valid | out_ready);
  // Depends only on state and out_ready, never on in_valid.
  assign in_ready = ~s1_valid | s2_adv;

  // Per-lane saturating subtract. Each lane is computed on its own 8 bits,
  // so no borrow can leak into the neighbouring lane. Overflow is only
  // possible when the operand signs differ and the result sign flips away
  // from the minuend's sign.
  always_comb begin
    diff_dat = '0;
    diff_sat = '0;
    a_l      = '0;
    b_l      = '0;
    d_l      = '0;
    for (int k = 0; k < LANES; k++) begin
      a_l = s1_op.a[8*k +: 8];
      b_l = s1_op.b[8*k +: 8];
      d_l = a_l - b_l;
      if ((a_l[7] != b_l[7]) && (d_l[7] != a_l[7])) begin
        diff_dat[8*k +: 8] = a_l[7] ? 8'h80 : 8'h7F;
        diff_sat[k]        = 1'b1;
      end else begin
        diff_dat[8*k +: 8] = d_l;
      end
    end
  end

  // Stage 1: operand capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_op    <= '0;
    end else begin
      if (in_valid && in_ready) begin
        s1_valid <= 1'b1;
        s1_op.a  <= in1;
        s1_op.b  <= in2;
      end else if (s2_adv) begin
        s1_valid <= 1'b0;
      end
    end
  end

  // Stage 2: result register, held while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out       <= '0;
      sat       <= '0;
    end else begin
      if (s2_adv) begin
        out_valid <= 1'b1;
        out       <= diff_dat;
        sat       <= diff_sat;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  // Sticky saturation: only results actually taken by the consumer count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_sticky <= 1'b0;
    end else if (out_valid && out_ready && (|sat)) begin
      sat_sticky <= 1'b1;
    end else if (clr_sticky) begin
      sat_sticky <= 1'b0;
    end
  end

`ifdef PSUB_FLAGS_EN
  // Flags travel with the result so they stay aligned under back-pressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zr  <= 1'b0;
      neg <= 1'b0;
      ov  <= 1'b0;
    end else if (s2_adv) begin
      zr  <= (diff_dat == '0);
      neg <= diff_dat[W-1];
      ov  <= |diff_sat;
    end
  end
`endif

endmodule

// File: tb/tb_psubsb_pipe.sv
// tb_psubsb_pipe: directed-vector bench for psubsb_pipe with a queue-based reference model.
// Latency: n/a (testbench).
// Backpressure: exercises out_ready stalls, sticky clear priority and asynchronous reset mid-flight.
module tb_psubsb_pipe;
  localparam int LANES = 2;
  localparam int W     = LANES * 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [W-1:0]     in1 = '0;
  logic [W-1:0]     in2 = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [W-1:0]     out;
  logic [LANES-1:0] sat;
  logic             sat_sticky;
  logic             clr_sticky = 1'b0;
`ifdef PSUB_FLAGS_EN
  logic             zr, neg, ov;
`endif

  psubsb_pipe #(.LANES(LANES)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in1        (in1),
    .in2        (in2),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out        (out),
    .sat        (sat),
    .sat_sticky (sat_sticky),
    .clr_sticky (clr_sticky)
`ifdef PSUB_FLAGS_EN
    ,
    .zr         (zr),
    .neg        (neg),
    .ov         (ov)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [W-1:0]     r;
    logic [LANES-1:0] s;
  } exp_t;

  exp_t             q[$];
  exp_t             me;
  int               acc_cnt = 0;
  int               out_cnt = 0;
  logic             m_sticky = 1'b0;
  logic             hold_pend = 1'b0;
  logic [W-1:0]     hold_out;
  logic [LANES-1:0] hold_sat;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: signed integer difference, clamped to the byte range per lane.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] r, output logic [LANES-1:0] s);
    int ai, bi, d;
    r = '0;
    s = '0;
    for (int k = 0; k < LANES; k++) begin
      ai = $signed(a[8*k +: 8]);
      bi = $signed(b[8*k +: 8]);
      d  = ai - bi;
      if (d > 127) begin
        d    = 127;
        s[k] = 1'b1;
      end else if (d < -128) begin
        d    = -128;
        s[k] = 1'b1;
      end
      r[8*k +: 8] = d[7:0];
    end
  endtask

  // Compare process: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("sticky", sat_sticky, m_sticky);
      if (hold_pend) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_out", out, hold_out);
        chk("hold_sat", sat, hold_sat);
      end
      hold_pend = out_valid && !out_ready;
      hold_out  = out;
      hold_sat  = sat;
      if (out_valid && out_ready) begin
        chk("spurious_out", (q.size() > 0), 1);
        if (q.size() > 0) begin
          me = q.pop_front();
          chk("out", out, me.r);
          chk("sat", sat, me.s);
`ifdef PSUB_FLAGS_EN
          chk("zr", zr, (me.r == '0));
          chk("neg", neg, me.r[W-1]);
          chk("ov", ov, |me.s);
`endif
        end
        out_cnt++;
      end
      if (in_valid && in_ready) begin
        model(in1, in2, me.r, me.s);
        q.push_back(me);
        acc_cnt++;
      end
      if (out_valid && out_ready && (|sat)) m_sticky = 1'b1;
      else if (clr_sticky)                  m_sticky = 1'b0;
    end
  end

  // Reset throws away everything in flight in the model as well.
  always @(negedge rst_n) begin
    q.delete();
    m_sticky  = 1'b0;
    hold_pend = 1'b0;
  end

  // Present one operand pair, starting at posedge+1; returns at posedge+1 after the handshake.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
    int n;
    n        = 0;
    in1      = a;
    in2      = b;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready) begin
      n++;
      if (n > 100) begin
        chk("send_timeout", in_ready, 1);
        break;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0]     r;
    logic [LANES-1:0] s;
    int base_acc, base_out;

    // Pin the reference model with hand-computed values.
    model(16'h0503, 16'h0201, r, s);
    chk("model_basic_r", r, 16'h0302);
    chk("model_basic_s", s, 2'b00);
    model(16'h7F00, 16'hFF80, r, s);
    chk("model_pos_r", r, 16'h7F7F);
    chk("model_pos_s", s, 2'b11);
    model(16'h8000, 16'h0101, r, s);
    chk("model_neg_r", r, 16'h80FF);
    chk("model_neg_s", s, 2'b10);

    // Reset state.
    #3;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out", out, 0);
    chk("rst_sat", sat, 0);
    chk("rst_sticky", sat_sticky, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", in_ready, 1);
    out_ready = 1'b1;

    // Single op and latency.
    in1 = 16'h0503; in2 = 16'h0201; in_valid = 1'b1;
    @(negedge clk);
    chk("lat_in_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("lat1_valid", out_valid, 0);
    @(negedge clk);
    chk("lat2_valid", out_valid, 1);
    chk("lat2_out", out, 16'h0302);
    chk("lat2_sat", sat, 2'b00);
    @(negedge clk);
    chk("basic_sticky", sat_sticky, 0);
    @(posedge clk); #1;

    // Positive saturation.
    send(16'h7F00, 16'hFF80);
    @(negedge clk); @(negedge clk);
    chk("pos_out", out, 16'h7F7F);
    chk("pos_sat", sat, 2'b11);
    @(negedge clk);
    chk("pos_sticky", sat_sticky, 1);
    @(posedge clk); #1;

    // Negative saturation, lane isolation.
    send(16'h8000, 16'h0101);
    @(negedge clk); @(negedge clk);
    chk("neg_out", out, 16'h80FF);
    chk("neg_sat", sat, 2'b10);
    @(posedge clk); #1;
    clr_sticky = 1'b1;
    @(posedge clk); #1;
    clr_sticky = 1'b0;
    @(negedge clk);
    chk("clr_sticky", sat_sticky, 0);
    @(posedge clk); #1;

    // Back-pressure: four ops against a stalled consumer.
    base_acc  = acc_cnt;
    base_out  = out_cnt;
    out_ready = 1'b0;
    fork
      begin
        send(16'h1020, 16'h0810);
        send(16'h0000, 16'h0001);
        send(16'h4050, 16'hC0B0);
        send(16'hFF01, 16'h01FF);
      end
      begin
        repeat (8) @(negedge clk);
        chk("bp_accepts", acc_cnt - base_acc, 2);
        chk("bp_in_ready", in_ready, 0);
        chk("bp_out_valid", out_valid, 1);
        chk("bp_out_first", out, 16'h0810);
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    repeat (8) @(negedge clk);
    chk("bp_all_out", out_cnt - base_out, 4);
    chk("bp_queue_empty", q.size(), 0);
    @(posedge clk); #1;

    // Sticky clear priority: set and clear in the same cycle.
    clr_sticky = 1'b1;
    @(posedge clk); #1;
    clr_sticky = 1'b0;
    out_ready  = 1'b0;
    send(16'h7F00, 16'hFF80);
    @(negedge clk); @(negedge clk);
    chk("prio_out_valid", out_valid, 1);
    @(posedge clk); #1;
    out_ready  = 1'b1;
    clr_sticky = 1'b1;
    @(posedge clk); #1;
    chk("prio_set_wins", sat_sticky, 1);
    @(posedge clk); #1;
    chk("prio_clear", sat_sticky, 0);
    clr_sticky = 1'b0;

    // Reset mid-flight: make sticky set, then park two ops and reset.
    send(16'h8000, 16'h0101);
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(16'h1111, 16'h0101);
    send(16'h2222, 16'h0101);
    chk("mid_sticky_before", sat_sticky, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_out_valid", out_valid, 0);
    chk("mid_sticky", sat_sticky, 0);
    #2;
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("mid_no_stale", out_valid, 0);
    end
    @(posedge clk); #1;

`ifdef PSUB_FLAGS_EN
    send(16'h1234, 16'h1234);
    @(negedge clk); @(negedge clk);
    chk("flag_out", out, 16'h0000);
    chk("flag_zr", zr, 1);
    chk("flag_neg", neg, 0);
    chk("flag_ov", ov, 0);
    @(posedge clk); #1;
`endif

    repeat (4) @(negedge clk);
    chk("drain_empty", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
